// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV32M multiply/divide unit feeding the register-file write port.
// An accepted operation runs one shift-add (multiply) or restoring-subtract (divide) step per
// clock. The result is presented as a one-cycle write-back strobe.
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous active-high reset, clears all state
//   start         request, accepted only while ready=1
//   flush         kill any in-flight op (no write-back); beats start in IDLE
//   op[2:0]       RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_val       operand A / dividend
//   rs2_val       operand B / divisor
//   rd_in[4:0]    destination register index
//   ready         high in IDLE only
//   busy          high in PREP, RUN, FIN
//   wb_valid      one-cycle result strobe
//   wb_rd[4:0]    destination index of the result
//   wb_data       result, held until the next wb_valid
//   wb_reg_write  wb_valid and wb_rd != 0
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            ready,
    output logic            busy,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_reg_write
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;       // raw rs2 until PREP, then its magnitude
    logic [4:0]          r_rd;
    logic [2*XLEN-1:0]   r_acc;     // mul: {high, low/multiplier}; div: {remainder, quotient/dividend}
    logic [CW-1:0]       r_cnt;
    logic                r_neg_q;   // negate product / quotient at FIN
    logic                r_neg_r;   // negate remainder at FIN
    logic                r_wb_valid;
    logic [4:0]          r_wb_rd;
    logic [XLEN-1:0]     r_wb_data;

    // Operand preparation (evaluated in PREP from the latched operands)
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_special;

    assign w_is_div   = r_op[2];
    assign w_a_signed = (r_op == OP_MULH) || (r_op == OP_MULHSU) || (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_b_signed = (r_op == OP_MULH) || (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_a_neg    = w_a_signed & r_a[XLEN-1];
    assign w_b_neg    = w_b_signed & r_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -r_a : r_a;
    assign w_b_mag    = w_b_neg ? -r_b : r_b;
    assign w_div_zero = w_is_div && (r_b == '0);
    assign w_div_ovf  = ((r_op == OP_DIV) || (r_op == OP_REM)) &&
                        (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    // One multiply step: conditionally add the multiplicand into the high half, shift right
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // One restoring divide step: shift in the next dividend bit, keep the subtraction if it fits
    logic [XLEN:0]       w_rem_shift;
    logic [XLEN:0]       w_rem_trial;
    logic [2*XLEN-1:0]   w_div_next;
    assign w_rem_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_rem_trial = w_rem_shift - {1'b0, r_b};
    assign w_div_next  = w_rem_trial[XLEN] ? {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                           : {w_rem_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // Sign fix-up and result selection
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_result;
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_result = w_prod[XLEN-1:0];
        if (w_is_div)
            w_result = r_op[1] ? w_rem : w_quo;
        else if (r_op != OP_MUL)
            w_result = w_prod[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; flush returns any busy state to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start && !flush) w_state_next = S_PREP;
            S_PREP: begin
                if (flush)          w_state_next = S_IDLE;
                else if (w_special) w_state_next = S_FIN;
                else                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (flush)                       w_state_next = S_IDLE;
                else if (r_cnt == CW'(1))        w_state_next = S_FIN;
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath and registered write-back stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rd       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op <= op;
                        r_a  <= rs1_val;
                        r_b  <= rs2_val;
                        r_rd <= rd_in;
                    end
                end
                S_PREP: begin
                    r_cnt <= CW'(XLEN);
                    if (w_special) begin
                        // Preload {remainder, quotient} so FIN's normal selection yields the fixed result
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_acc   <= w_div_zero ? {r_a, {XLEN{1'b1}}}
                                              : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                    end else begin
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                        r_b     <= w_b_mag;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                end
                S_FIN: begin
                    if (!flush) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready        = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_reg_write = r_wb_valid && (r_wb_rd != 5'd0);

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        ready;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;

    mdu_iterative #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .ready(ready), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_reg_write(wb_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference results straight from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 2;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        return 34;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Write-back checker: every strobe must match the model, at exactly the due cycle
    always @(negedge clk) begin
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] edata;
        ev    = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        erd   = ev ? exp_q[0].rd : 5'd0;
        edata = ev ? exp_q[0].data : 32'd0;
        if (ev || wb_valid || wb_reg_write) begin
            n_cmp++;
            if (wb_valid !== ev) begin
                n_fail++;
                $display("FAIL wb_valid: got %b, required %b (cycle %0d)", wb_valid, ev, cyc);
            end
            n_cmp++;
            if (wb_reg_write !== (ev && erd != 5'd0)) begin
                n_fail++;
                $display("FAIL wb_reg_write: got %b, required %b (cycle %0d)", wb_reg_write, ev && erd != 5'd0, cyc);
            end
            if (ev) begin
                n_cmp++;
                if (wb_data !== edata) begin
                    n_fail++;
                    $display("FAIL wb_data: got %h, required %h (cycle %0d)", wb_data, edata, cyc);
                end
                n_cmp++;
                if (wb_rd !== erd) begin
                    n_fail++;
                    $display("FAIL wb_rd: got %0d, required %0d (cycle %0d)", wb_rd, erd, cyc);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns just after the accepting edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit track);
        exp_t e;
        start   = 1'b1;
        op      = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        if (track) begin
            e.due  = cyc + 1 + latency(f, a, b);
            e.rd   = rd;
            e.data = model(f, a, b);
            exp_q.push_back(e);
        end
        step();
        start   = 1'b0;
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_in   = 5'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: %0d results still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    logic [2:0]  tv_op [8];
    logic [31:0] tv_a  [8];
    logic [31:0] tv_b  [8];

    initial begin
        int t0;
        reset   = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 3'd0;
        rs1_val = '0;
        rs2_val = '0;
        rd_in   = '0;
        step();
        step();

        chk("reset_ready",  {31'b0, ready},        32'd1);
        chk("reset_busy",   {31'b0, busy},         32'd0);
        chk("reset_wbv",    {31'b0, wb_valid},     32'd0);
        chk("reset_wbrw",   {31'b0, wb_reg_write}, 32'd0);
        chk("reset_wbrd",   {27'b0, wb_rd},        32'd0);
        chk("reset_wbdata", wb_data,               32'd0);
        reset = 1'b0;
        step();

        // Pin the model against hand-computed values
        chk("model_mul",    model(3'd0, 32'd7, 32'hFFFFFFFD),          32'hFFFFFFEB);
        chk("model_mulhu",  model(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF),   32'hFFFFFFFE);
        chk("model_mulh",   model(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF),   32'h00000000);
        chk("model_mulhsu", model(3'd2, 32'hFFFFFFFF, 32'd2),          32'hFFFFFFFF);
        chk("model_div",    model(3'd4, 32'hFFFFFFF9, 32'd2),          32'hFFFFFFFD);
        chk("model_rem",    model(3'd6, 32'hFFFFFFF9, 32'd2),          32'hFFFFFFFF);
        chk("model_divu",   model(3'd5, 32'd100, 32'd7),               32'd14);
        chk("model_remu",   model(3'd7, 32'd100, 32'd7),               32'd2);
        chk("model_rem0",   model(3'd6, 32'h80000000, 32'd0),          32'h80000000);
        chk("model_divovf", model(3'd4, 32'h80000000, 32'hFFFFFFFF),   32'h80000000);

        // First op also checks the busy indication
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1);
        chk("busy_after_accept",  {31'b0, busy},  32'd1);
        chk("ready_after_accept", {31'b0, ready}, 32'd0);
        wait_idle();

        tv_op = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd2};
        tv_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                  32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000};
        tv_b  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFF};
        for (int i = 0; i < 8; i++) begin
            issue(tv_op[i], tv_a[i], tv_b[i], 5'(i + 10), 1'b1);
            wait_idle();
        end

        // Special cases: divide by zero and signed overflow
        issue(3'd5, 32'd5, 32'd0, 5'd1, 1'b1);                       wait_idle();
        issue(3'd6, 32'h80000000, 32'd0, 5'd2, 1'b1);                wait_idle();
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd3, 1'b1);         wait_idle();
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd4, 1'b1);         wait_idle();
        issue(3'd4, 32'h12345678, 32'd0, 5'd6, 1'b1);                wait_idle();
        issue(3'd4, 32'h80000000, 32'd3, 5'd6, 1'b1);                wait_idle();

        // rd=0: strobe without register write
        issue(3'd0, 32'd3, 32'd4, 5'd0, 1'b1);
        wait_idle();

        // start while busy is ignored
        issue(3'd3, 32'hDEADBEEF, 32'hCAFEF00D, 5'd20, 1'b1);
        repeat (3) step();
        start = 1'b1; op = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd21;
        step();
        start = 1'b0;
        wait_idle();

        // flush mid-run, then a new op right away
        issue(3'd0, 32'd123, 32'd456, 5'd22, 1'b0);
        t0 = cyc;
        while (cyc < t0 + 9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready", {31'b0, ready}, 32'd1);
        chk("flush_busy",  {31'b0, busy},  32'd0);
        issue(3'd5, 32'd1000, 32'd10, 5'd9, 1'b1);
        wait_idle();

        // flush and start together in IDLE
        flush = 1'b1; start = 1'b1; op = 3'd0; rs1_val = 32'd2; rs2_val = 32'd2; rd_in = 5'd23;
        step();
        flush = 1'b0; start = 1'b0;
        chk("flushstart_busy", {31'b0, busy}, 32'd0);
        repeat (40) step();

        // Asynchronous reset between edges mid-run
        issue(3'd0, 32'd123, 32'd456, 5'd3, 1'b0);
        repeat (8) step();
        #2 reset = 1'b1;
        #1;
        chk("areset_wbdata", wb_data,          32'd0);
        chk("areset_wbrd",   {27'b0, wb_rd},   32'd0);
        chk("areset_ready",  {31'b0, ready},   32'd1);
        chk("areset_busy",   {31'b0, busy},    32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (40) step();

        // Back-to-back: second start in the first op's write-back cycle
        issue(3'd0, 32'h00001234, 32'h00005678, 5'd7, 1'b1);
        t0 = cyc;
        while (cyc < t0 + 34) step();
        chk("b2b_ready", {31'b0, ready}, 32'd1);
        issue(3'd3, 32'h89ABCDEF, 32'h12345678, 5'd8, 1'b1);
        wait_idle();
        repeat (5) step();

        chk("pending_results", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
